// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline register.
// Holds default widths, the reset / exception-vector PCs, the stage state
// encoding and the record carried between stages.
package pipe_pkg;

    localparam int PIPE_PC_W   = 32;
    localparam int PIPE_DATA_W = 64;
    localparam int PIPE_EXC_W  = 5;

    localparam logic [31:0] PIPE_EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] PIPE_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_SKIDDED = 2'd2
    } state_e;

    // One pipeline entry at the default widths.
    typedef struct packed {
        logic [PIPE_PC_W-1:0]   pc;
        logic [PIPE_DATA_W-1:0] data;
        logic                   bd;
        logic [PIPE_EXC_W-1:0]  exc;
    } slot_t;

    // Number of entries held in a given state.
    function automatic logic [1:0] state_occ(input state_e s);
        case (s)
            ST_FULL:    state_occ = 2'd1;
            ST_SKIDDED: state_occ = 2'd2;
            default:    state_occ = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry register (pc, payload, delay-slot flag, exception code).
// Priority inside the slot: load-vector > clear > load; pc survives a clear.
// Latency: 1 cycle from control to output; no handshake of its own.
module pipe_slot #(
    parameter int              PC_W   = 32,
    parameter int              DATA_W = 64,
    parameter int              EXC_W  = 5,
    parameter logic [PC_W-1:0] RST_PC = '0,
    parameter logic [PC_W-1:0] VEC_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_i,
    input  logic              clr_i,
    input  logic              vec_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              bd_i,
    input  logic [EXC_W-1:0]  exc_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [DATA_W-1:0] data_o,
    output logic              bd_o,
    output logic [EXC_W-1:0]  exc_o
);

    logic [PC_W-1:0]   pc_q,   pc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              bd_q,   bd_d;
    logic [EXC_W-1:0]  exc_q,  exc_d;

    // Next-state: a cleared slot decodes as a nop but keeps its pc.
    always_comb begin
        pc_d   = pc_q;
        data_d = data_q;
        bd_d   = bd_q;
        exc_d  = exc_q;
        if (vec_i) begin
            pc_d   = VEC_PC;
            data_d = '0;
            bd_d   = 1'b0;
            exc_d  = '0;
        end else if (clr_i) begin
            data_d = '0;
            bd_d   = 1'b0;
            exc_d  = '0;
        end else if (ld_i) begin
            pc_d   = pc_i;
            data_d = data_i;
            bd_d   = bd_i;
            exc_d  = exc_i;
        end
    end

    // Record register with synchronous reset to the reset PC and a nop payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RST_PC;
            data_q <= '0;
            bd_q   <= 1'b0;
            exc_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            data_q <= data_d;
            bd_q   <= bd_d;
            exc_q  <= exc_d;
        end
    end

    assign pc_o   = pc_q;
    assign data_o = data_q;
    assign bd_o   = bd_q;
    assign exc_o  = exc_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with valid/ready handshake and optional skid entry.
// Latency: 1 cycle in->out when not blocked; outputs always show the main entry.
// Backpressure: SKID=1 absorbs one extra entry and drives in_ready from a flop; SKID=0 is combinational.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int              DATA_W   = 64,
    parameter int              PC_W     = PIPE_PC_W,
    parameter int              EXC_W    = PIPE_EXC_W,
    parameter logic [PC_W-1:0] EXC_VEC  = PC_W'(PIPE_EXC_VEC),
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(PIPE_RESET_PC),
    parameter int              SKID     = 1,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_bd,
    input  logic [EXC_W-1:0]  in_exc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bd,
    output logic [EXC_W-1:0]  out_exc,
    input  logic              flush,
    input  logic              req,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    state_e state_q, state_d;
    logic   vld;
    logic   in_fire, out_fire;

    logic   main_ld, main_clr, main_vec, main_src_skid;
    logic   skid_ld, skid_clr;

    logic [PC_W-1:0]   main_pc,   skid_pc,   main_pc_in;
    logic [DATA_W-1:0] main_data, skid_data, main_data_in;
    logic              main_bd,   skid_bd,   main_bd_in;
    logic [EXC_W-1:0]  main_exc,  skid_exc,  main_exc_in;

    logic [CNT_W-1:0]  bubble_q;

    assign vld      = (state_q != ST_EMPTY);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = vld && out_ready;

    // in_ready: registered copy of "next state is not SKIDDED", or the plain
    // single-register rule when there is no skid entry.
    if (SKID != 0) begin : g_rdy_reg
        logic rdy_q;
        // Ready flop follows the next state so it never sees out_ready combinationally.
        always_ff @(posedge clk) begin
            if (reset) rdy_q <= 1'b1;
            else       rdy_q <= (state_d != ST_SKIDDED);
        end
        assign in_ready = rdy_q;
    end else begin : g_rdy_comb
        assign in_ready = !vld || out_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    // Next-state: req/flush empty the stage and drop any same-cycle input.
    always_comb begin
        state_d = state_q;
        if (req || flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) state_d = ST_FULL;
                end
                ST_FULL: begin
                    if (in_fire && !out_fire)
                        state_d = (SKID != 0) ? ST_SKIDDED : ST_FULL;
                    else if (!in_fire && out_fire)
                        state_d = ST_EMPTY;
                end
                ST_SKIDDED: begin
                    if (out_fire) state_d = ST_FULL;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Output / datapath controls: which slot loads, clears or takes the vector.
    always_comb begin
        main_ld       = 1'b0;
        main_clr      = 1'b0;
        main_vec      = 1'b0;
        main_src_skid = 1'b0;
        skid_ld       = 1'b0;
        skid_clr      = 1'b0;
        if (req) begin
            main_vec = 1'b1;
            skid_clr = 1'b1;
        end else if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) main_ld = 1'b1;
                end
                ST_FULL: begin
                    if (in_fire && out_fire) main_ld  = 1'b1;
                    else if (in_fire)        skid_ld  = 1'b1;
                    else if (out_fire)       main_clr = 1'b1;
                end
                ST_SKIDDED: begin
                    if (out_fire) begin
                        main_ld       = 1'b1;
                        main_src_skid = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign main_pc_in   = main_src_skid ? skid_pc   : in_pc;
    assign main_data_in = main_src_skid ? skid_data : in_data;
    assign main_bd_in   = main_src_skid ? skid_bd   : in_bd;
    assign main_exc_in  = main_src_skid ? skid_exc  : in_exc;

    pipe_slot #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W),
        .EXC_W  (EXC_W),
        .RST_PC (RESET_PC),
        .VEC_PC (EXC_VEC)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .ld_i   (main_ld),
        .clr_i  (main_clr),
        .vec_i  (main_vec),
        .pc_i   (main_pc_in),
        .data_i (main_data_in),
        .bd_i   (main_bd_in),
        .exc_i  (main_exc_in),
        .pc_o   (main_pc),
        .data_o (main_data),
        .bd_o   (main_bd),
        .exc_o  (main_exc)
    );

    if (SKID != 0) begin : g_skid
        pipe_slot #(
            .PC_W   (PC_W),
            .DATA_W (DATA_W),
            .EXC_W  (EXC_W),
            .RST_PC (RESET_PC),
            .VEC_PC (EXC_VEC)
        ) u_skid (
            .clk    (clk),
            .reset  (reset),
            .ld_i   (skid_ld),
            .clr_i  (skid_clr),
            .vec_i  (1'b0),
            .pc_i   (in_pc),
            .data_i (in_data),
            .bd_i   (in_bd),
            .exc_i  (in_exc),
            .pc_o   (skid_pc),
            .data_o (skid_data),
            .bd_o   (skid_bd),
            .exc_o  (skid_exc)
        );
    end else begin : g_no_skid
        logic unused_skid_ctl;
        assign unused_skid_ctl = skid_ld | skid_clr;
        assign skid_pc   = '0;
        assign skid_data = '0;
        assign skid_bd   = 1'b0;
        assign skid_exc  = '0;
    end

    // Saturating count of cycles where nothing is presented downstream.
    always_ff @(posedge clk) begin
        if (reset)
            bubble_q <= '0;
        else if (!vld && (bubble_q != {CNT_W{1'b1}}))
            bubble_q <= bubble_q + 1'b1;
    end

    assign out_valid  = vld;
    assign out_pc     = main_pc;
    assign out_data   = vld ? main_data : '0;
    assign out_bd     = vld && main_bd;
    assign out_exc    = vld ? main_exc : '0;
    assign occupancy  = state_occ(state_q);
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: SKID=1, default widths.
    logic        reset, in_valid, in_ready, in_bd, out_valid, out_ready, out_bd, flush, req;
    logic [31:0] in_pc, out_pc;
    logic [63:0] in_data, out_data;
    logic [4:0]  in_exc, out_exc;
    logic [1:0]  occupancy;
    logic [15:0] bubble_cnt;

    // Second DUT: SKID=0, 4-bit bubble counter.
    logic        z_reset, z_in_valid, z_in_ready, z_in_bd, z_out_valid, z_out_ready, z_out_bd;
    logic        z_flush, z_req;
    logic [31:0] z_in_pc, z_out_pc;
    logic [63:0] z_in_data, z_out_data;
    logic [4:0]  z_in_exc, z_out_exc;
    logic [1:0]  z_occupancy;
    logic [3:0]  z_bubble_cnt;

    int checks = 0;
    int failures = 0;

    pipe_skid_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_data(in_data), .in_bd(in_bd), .in_exc(in_exc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_data(out_data), .out_bd(out_bd), .out_exc(out_exc),
        .flush(flush), .req(req), .occupancy(occupancy), .bubble_cnt(bubble_cnt)
    );

    pipe_skid_stage #(.SKID(0), .CNT_W(4)) dut0 (
        .clk(clk), .reset(z_reset), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .in_pc(z_in_pc), .in_data(z_in_data), .in_bd(z_in_bd), .in_exc(z_in_exc),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_pc(z_out_pc),
        .out_data(z_out_data), .out_bd(z_out_bd), .out_exc(z_out_exc),
        .flush(z_flush), .req(z_req), .occupancy(z_occupancy), .bubble_cnt(z_bubble_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a FIFO of at most two entries ----------------
    slot_t       q[$];
    logic [31:0] held_pc;
    logic [15:0] m_cnt;
    bit          mdl_live = 0;
    bit          m_of, m_if;
    slot_t       m_e;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            held_pc  = 32'h0;
            m_cnt    = 16'h0;
            mdl_live = 1;
        end else if (mdl_live) begin
            if (q.size() == 0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
            if (req) begin
                q.delete();
                held_pc = 32'h0000_4180;
            end else if (flush) begin
                if (q.size() > 0) held_pc = q[0].pc;
                q.delete();
            end else begin
                m_of = (q.size() > 0) && out_ready;
                m_if = in_valid && (q.size() < 2);
                if (m_of) begin
                    held_pc = q[0].pc;
                    void'(q.pop_front());
                end
                if (m_if) begin
                    m_e.pc = in_pc; m_e.data = in_data; m_e.bd = in_bd; m_e.exc = in_exc;
                    q.push_back(m_e);
                end
            end
        end
    end

    // Compare every cycle against the model, away from the active edge.
    always @(negedge clk) begin
        if (mdl_live) begin
            if (q.size() > 0) begin
                chk("m_pc",   64'(out_pc),   64'(q[0].pc));
                chk("m_data", out_data,      q[0].data);
                chk("m_bd",   64'(out_bd),   64'(q[0].bd));
                chk("m_exc",  64'(out_exc),  64'(q[0].exc));
            end else begin
                chk("m_pc",   64'(out_pc),   64'(held_pc));
                chk("m_data", out_data,      64'h0);
                chk("m_bd",   64'(out_bd),   64'h0);
                chk("m_exc",  64'(out_exc),  64'h0);
            end
            chk("m_valid", 64'(out_valid),  64'(q.size() > 0));
            chk("m_ready", 64'(in_ready),   64'(q.size() < 2));
            chk("m_occ",   64'(occupancy),  64'(q.size()));
            chk("m_bcnt",  64'(bubble_cnt), 64'(m_cnt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_data  = {$urandom, $urandom};
        in_bd    = 1'($urandom_range(0, 1));
        in_exc   = 5'($urandom_range(0, 31));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1; in_valid = 0; in_pc = 0; in_data = 0; in_bd = 0; in_exc = 0;
        out_ready = 0; flush = 0; req = 0;
        z_reset = 1; z_in_valid = 0; z_in_pc = 0; z_in_data = 0; z_in_bd = 0; z_in_exc = 0;
        z_out_ready = 0; z_flush = 0; z_req = 0;
        cyc(); cyc();
        reset = 0;
        chk("rst_valid", 64'(out_valid),  64'h0);
        chk("rst_pc",    64'(out_pc),     64'h0);
        chk("rst_data",  out_data,        64'h0);
        chk("rst_occ",   64'(occupancy),  64'h0);
        chk("rst_bcnt",  64'(bubble_cnt), 64'h0);
        chk("rst_ready", 64'(in_ready),   64'h1);

        // Streaming: one entry per cycle, out_pc one cycle behind.
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            drive(32'h3000 + 32'(4 * i));
            cyc();
            chk("str_pc",    64'(out_pc),    64'(32'h3000 + 32'(4 * i)));
            chk("str_occ",   64'(occupancy), 64'h1);
            chk("str_ready", 64'(in_ready),  64'h1);
        end
        chk("str_bcnt", 64'(bubble_cnt), 64'h1);
        in_valid = 0;
        cyc();
        chk("drain_valid", 64'(out_valid), 64'h0);
        chk("drain_pc",    64'(out_pc),    64'h3014);
        chk("drain_data",  out_data,       64'h0);

        // Backpressure into the skid entry, then ordered release.
        out_ready = 0;
        drive(32'h3000); cyc();
        chk("bp_pc0",   64'(out_pc),    64'h3000);
        chk("bp_rdy0",  64'(in_ready),  64'h1);
        drive(32'h3004); cyc();
        chk("bp_occ2",  64'(occupancy), 64'h2);
        chk("bp_rdy1",  64'(in_ready),  64'h0);
        drive(32'h3008); cyc();
        chk("bp_hold",  64'(out_pc),    64'h3000);
        chk("bp_occ2b", 64'(occupancy), 64'h2);
        out_ready = 1; cyc();
        chk("bp_pc1",   64'(out_pc),    64'h3004);
        chk("bp_rdy2",  64'(in_ready),  64'h1);
        cyc();
        chk("bp_pc2",   64'(out_pc),    64'h3008);
        in_valid = 0; cyc();
        chk("bp_empty", 64'(out_valid), 64'h0);

        // Flush with two entries held and an input presented.
        out_ready = 0;
        drive(32'h5000); cyc();
        drive(32'h5004); cyc();
        chk("fl_occ_pre", 64'(occupancy), 64'h2);
        flush = 1; drive(32'h5008); cyc();
        flush = 0; in_valid = 0;
        chk("fl_valid", 64'(out_valid), 64'h0);
        chk("fl_data",  out_data,       64'h0);
        chk("fl_exc",   64'(out_exc),   64'h0);
        chk("fl_occ",   64'(occupancy), 64'h0);
        chk("fl_pc",    64'(out_pc),    64'h5000);
        chk("fl_ready", 64'(in_ready),  64'h1);
        cyc();
        chk("fl_drop",  64'(out_valid), 64'h0);

        // req overrides flush and the presented input.
        drive(32'h6000); cyc();
        req = 1; flush = 1; drive(32'h6004); in_exc = 5'd4; in_bd = 1'b1; cyc();
        req = 0; flush = 0; in_valid = 0;
        chk("rq_pc",    64'(out_pc),    64'h4180);
        chk("rq_valid", 64'(out_valid), 64'h0);
        chk("rq_exc",   64'(out_exc),   64'h0);
        chk("rq_bd",    64'(out_bd),    64'h0);

        // Reset mid-stall with both entries occupied.
        drive(32'h7000); cyc();
        drive(32'h7004); cyc();
        chk("rs_occ_pre", 64'(occupancy), 64'h2);
        reset = 1; in_valid = 0; cyc();
        reset = 0;
        chk("rs_pc",    64'(out_pc),     64'h0);
        chk("rs_valid", 64'(out_valid),  64'h0);
        chk("rs_data",  out_data,        64'h0);
        chk("rs_ready", 64'(in_ready),   64'h1);
        chk("rs_occ",   64'(occupancy),  64'h0);
        chk("rs_bcnt",  64'(bubble_cnt), 64'h0);
        out_ready = 1;
        repeat (3) cyc();
        chk("rs_noskid", 64'(out_valid), 64'h0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) != 0) drive($urandom);
            else in_valid = 0;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            req       = ($urandom_range(0, 63) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            cyc();
        end
        in_valid = 0; flush = 0; req = 0; reset = 0; out_ready = 1;
        cyc();

        // SKID=0 build: combinational in_ready and 4-bit counter saturation.
        z_reset = 0; z_out_ready = 0;
        z_in_valid = 1; z_in_pc = 32'h8000; z_in_data = 64'h1234; z_in_exc = 5'd3;
        cyc();
        z_in_pc = 32'h8004; z_in_data = 64'h5678; z_in_exc = 5'd0;
        chk("z_pc0",    64'(z_out_pc),    64'h8000);
        chk("z_data0",  z_out_data,       64'h1234);
        chk("z_rdy0",   64'(z_in_ready),  64'h0);
        z_out_ready = 1;
        #1;
        chk("z_rdy1",   64'(z_in_ready),  64'h1);
        cyc();
        chk("z_pc1",    64'(z_out_pc),    64'h8004);
        z_in_valid = 0;
        cyc();
        chk("z_empty",  64'(z_out_valid), 64'h0);
        chk("z_bcnt1",  64'(z_bubble_cnt), 64'h1);
        repeat (20) cyc();
        chk("z_bsat",   64'(z_bubble_cnt), 64'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised inter-stage pipeline register (F/D, D/E, E/M, M/W) that replaces fixed per-stage registers with stall-only control.
- Carries PC, an instruction/control payload, delay-slot flag and exception code.
- Uses a valid/ready handshake with an optional 2-entry skid buffer, so in_ready is registered and never depends combinationally on out_ready.
- Supports bubble flush and exception redirect (req), plus a saturating bubble counter for performance checks.

Parameters:
DATA_W, 64, payload width (op, fuc, rs, rt, rd, imm, shamt, as packed by the producing stage)
PC_W, 32, PC width
EXC_W, 5, exception-code width
EXC_VEC, 32'h0000_4180, out_pc loaded on req
RESET_PC, 32'h0000_0000, out_pc loaded on reset
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register, in_ready = !out_valid || out_ready
CNT_W, 16, bubble-counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept this cycle
in_pc  in  PC_W  upstream PC
in_data  in  DATA_W  upstream payload
in_bd  in  1  upstream delay-slot flag
in_exc  in  EXC_W  upstream exception code (0 = none)
out_valid  out  1  downstream entry valid
out_ready  in  1  downstream accepts
out_pc  out  PC_W  held PC
out_data  out  DATA_W  held payload (all-zero when !out_valid)
out_bd  out  1  held delay-slot flag (0 when !out_valid)
out_exc  out  EXC_W  held exception code (0 when !out_valid)
flush  in  1  kill contents and insert a bubble
req  in  1  exception redirect
occupancy  out  2  entries held (0..2)
bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0

Behaviour:
- Reset, reset = 1 and clk edge:
  - occupancy = 0, out_valid = 0.
  - out_data, out_bd, out_exc = 0; out_pc = RESET_PC.
  - bubble_cnt = 0.
  - in_ready = 1 from the following cycle.
- Fire definitions: in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- Priority, highest first: reset > req > flush > normal.
- State machine for SKID = 1, states EMPTY / FULL / SKIDDED:
  - EMPTY:
    - in_fire: main <= in, go to FULL.
  - FULL:
    - in_fire && out_fire: main <= in, stay in FULL.
    - in_fire && !out_fire: skid <= in, go to SKIDDED.
    - out_fire only: go to EMPTY.
  - SKIDDED:
    - in_ready = 0.
    - out_fire: main <= skid, go to FULL.
- Outputs:
  - Outputs always reflect the main entry; latency in→out is 1 cycle when not blocked.
  - in_ready = (state != SKIDDED), driven from a flop.
- SKID = 0: SKIDDED is unreachable; in_ready is combinational.
- Draining to EMPTY:
  - out_data, out_bd, out_exc are zeroed, so the bubble decodes as a nop.
  - out_pc retains the drained PC.
- flush:
  - Both entries are invalidated and payload, bd and exc zeroed; out_pc unchanged.
  - Any same-cycle in_fire is dropped, and in_ready = 1 next cycle.
  - If out_fire occurs in the same cycle, that entry is still considered consumed downstream.
- req:
  - Same as flush, except out_pc <= EXC_VEC.
  - req overrides flush and all input.
- Ordering and integrity:
  - Strict FIFO order.
  - No entry is duplicated or lost, except by flush, req or reset.
- bubble_cnt increments each non-reset cycle with out_valid = 0; it saturates at all-ones.
- Reset mid-operation discards all entries immediately, including the skid entry.

Decomposition:
- Package pipe_pkg:
  - PC_W and EXC_W defaults.
  - EXC_VEC and RESET_PC constants.
  - State enum {EMPTY, FULL, SKIDDED}.
  - Typedef for the slot record {pc, data, bd, exc}.
- Sub-module pipe_slot: one record register with load/clear/load-vector controls. It is instantiated twice (main, skid); the skid instance is generated only when SKID = 1.

Test Plan:
- Stream: in_valid = 1 every cycle, pc = 0x3000, 0x3004, …, out_ready = 1 → out_pc follows 1 cycle later; occupancy = 1; in_ready stays 1; bubble_cnt stops incrementing.
- Backpressure: out_ready = 0 while sending 0x3000, 0x3004, 0x3008 →
  - 0x3000 is held in main and 0x3004 in skid.
  - in_ready = 0 the cycle after skid load; occupancy = 2; 0x3008 is not accepted.
  - Raising out_ready delivers 0x3000, then 0x3004, then 0x3008 in order, with no loss.
- Flush with occupancy = 2 and in_valid = 1 → next cycle out_valid = 0, out_data = 0, out_exc = 0, occupancy = 0, out_pc unchanged; the input is dropped.
- req with flush also asserted and in_exc = 4 presented → out_pc = 0x00004180, out_valid = 0, out_exc = 0, out_bd = 0.
- Reset asserted mid-stall with occupancy = 2 → next cycle all outputs zero, out_pc = 0, in_ready = 1; the skid contents never appear.
- SKID = 0 build → out_ready = 0 with a full stage gives in_ready = 0 the same cycle; out_ready = 1 gives in_ready = 1 combinationally; bubble_cnt with CNT_W = 4 saturates at 15.
